readout_integrator: RTL and testbench
=====================================

# readout_integrator

Boxcar integrator for the dispersive-readout chain. Sits directly downstream of the down-mixer: it accepts the signed baseband I/Q stream and sums a programmable number of valid samples per measurement window. It then presents the two window sums with a one-cycle valid pulse to the state discriminator.

## Interface
- INPUT_WIDTH, 16: signed width of each baseband I/Q sample (down-mixer output width).
- ACC_WIDTH, 32: signed width of each accumulator; must be ≥ INPUT_WIDTH.
- LEN_WIDTH, 12: width of the window-length field; max window 2^LEN_WIDTH−1 samples.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to open a window; sampled only in IDLE.
- length  in  LEN_WIDTH  window length in valid samples; latched when start is accepted.
- in_valid  in  1  i_in/q_in carry a valid sample this cycle.
- i_in  in  INPUT_WIDTH  signed baseband I sample.
- q_in  in  INPUT_WIDTH  signed baseband Q sample.
- busy  out  1  high in ACCUM and DONE.
- out_valid  out  1  one-cycle pulse; sums are final.
- i_acc_out  out  ACC_WIDTH  signed I sum of the last completed window.
- q_acc_out  out  ACC_WIDTH  signed Q sum of the last completed window.
- ovf  out  1  sticky per window; set if any I or Q add overflowed ACC_WIDTH.

## Operation
- FSM states: IDLE, ACCUM, DONE. Reset state is IDLE.
- IDLE, start=1, length≠0:
  - latch length;
  - clear both accumulators, sample counter and ovf;
  - go to ACCUM.
- IDLE, start=1, length=0: ignored; stay in IDLE with no pulse.
- A sample present in the same cycle as an accepted start is not counted. The window begins on the next cycle.
- ACCUM, in_valid=1:
  - add the sign-extended i_in to the I accumulator and q_in to the Q accumulator;
  - increment the counter.
- ACCUM, in_valid=0: hold all state. Gaps in in_valid are allowed.
- When the accepted sample makes counter == latched length, go to DONE on that same edge.
- DONE: out_valid=1 for exactly one cycle, then go to IDLE.
- start is ignored in ACCUM and DONE, with no abort or restart. A new window can be accepted at the earliest in the first IDLE cycle after DONE.
- i_acc_out and q_acc_out are the accumulator registers. They hold the previous window's sums until the next accepted start clears them, and they are only meaningful while out_valid=1.
- Overflow is detected on each lane as: operands of equal sign and a result of different sign. A detected overflow sets ovf, which stays set until the next accepted start.
- Reset mid-window: all state returns to reset values immediately and the partial sums are discarded.

## Timing
- Reset values: busy=0, out_valid=0, i_acc_out=0, q_acc_out=0, ovf=0, counter=0, FSM=IDLE.
- start is accepted at edge S. busy=1 from S to the edge at which the FSM returns to IDLE.
- The last sample is accepted at edge N, which moves the FSM to DONE. out_valid is high in cycle N→N+1, and the sums are final in that cycle. Edge N+1 returns to IDLE.
- Throughput is one sample per clock. The minimum window period is length+2 cycles: one IDLE/start cycle, length ACCUM cycles and one DONE cycle.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- READOUT_INTEGRATOR_SATURATE_EN:
  - Defined: on overflow the lane clamps to +2^(ACC_WIDTH−1)−1 or −2^(ACC_WIDTH−1), following operand sign, and stays clamped until the result returns in range through later adds. ovf is still set.
  - Undefined: two's-complement wrap-around; ovf is set.
- Ports are identical in both builds.

## Structure
- Package readout_pkg holds:
  - the FSM state typedef (IDLE/ACCUM/DONE);
  - the default INPUT_WIDTH/ACC_WIDTH/LEN_WIDTH constants;
  - the ACC_MAX/ACC_MIN constants.
- Sub-module readout_acc_lane is instanced twice, once for I and once for Q. It contains the sign-extend, the add, overflow detection, the optional saturation and the accumulator register, with clear and enable inputs.
- The top level holds the FSM, the counter, the length latch and the ovf OR.

## Test plan
- Reset, then start with length=4 and samples I={1,2,3,4}, Q={−1,−1,−1,−1}, in_valid continuous → out_valid pulses once, 5 cycles after start, with i_acc_out=10, q_acc_out=−4, ovf=0.
- length=3 with in_valid toggling 1,0,0,1,0,1 and I=Q=100 → out_valid on the cycle after the third valid sample, with sums 300/300.
- start with length=0, then start asserted during ACCUM and during DONE → no new window and no extra out_valid; sums unchanged.
- ACC_WIDTH=16, INPUT_WIDTH=16, length=2, I=32767 twice:
  - macro undefined → i_acc_out=−2, ovf=1;
  - macro defined → i_acc_out=32767, ovf=1.
- Assert rst midway through a length=8 window → all outputs return to 0 asynchronously. A subsequent length=2 window sums correctly with no residue.
- Back-to-back windows with start held high continuously, length=1 → out_valid every 3 cycles, and each sum equals its single sample.

Source files
------------

// File: rtl/readout_pkg.sv
// Shared types and constants for the readout boxcar integrator.
package readout_pkg;

   localparam int unsigned DEF_INPUT_WIDTH = 16;
   localparam int unsigned DEF_ACC_WIDTH   = 32;
   localparam int unsigned DEF_LEN_WIDTH   = 12;

   localparam logic signed [DEF_ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(DEF_ACC_WIDTH-1){1'b1}}};
   localparam logic signed [DEF_ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(DEF_ACC_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

endpackage

// File: rtl/readout_acc_lane.sv
// One accumulator lane: sign-extend, add, overflow detect, optional clamp.
// Clamping is enabled by READOUT_INTEGRATOR_SATURATE_EN.
module readout_acc_lane
   import readout_pkg::*;
#(
   parameter int unsigned INPUT_WIDTH = DEF_INPUT_WIDTH,
   parameter int unsigned ACC_WIDTH   = DEF_ACC_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr,
   input  logic                          en,
   input  logic signed [INPUT_WIDTH-1:0] din,
   output logic signed [ACC_WIDTH-1:0]   acc,
   output logic                          ovf_det
);

`ifdef READOUT_INTEGRATOR_SATURATE_EN
   localparam logic signed [ACC_WIDTH-1:0] LANE_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] LANE_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

   logic signed [ACC_WIDTH-1:0] ext;
   logic signed [ACC_WIDTH-1:0] sum;
   logic signed [ACC_WIDTH-1:0] acc_q;
   logic signed [ACC_WIDTH-1:0] acc_d;
   logic                        ovf;

   always_comb begin
      ext = ACC_WIDTH'(din);
      sum = acc_q + ext;
      // Same-sign operands producing an opposite-sign result.
      ovf = (acc_q[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
            (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
`ifdef READOUT_INTEGRATOR_SATURATE_EN
         if (ovf) acc_d = acc_q[ACC_WIDTH-1] ? LANE_MIN : LANE_MAX;
         else     acc_d = sum;
`else
         acc_d = sum;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
   end

   assign acc     = acc_q;
   assign ovf_det = en && !clr && ovf;

endmodule

// File: rtl/readout_integrator.sv
// Boxcar integrator summing a programmable number of valid I/Q samples per window.
// Define READOUT_INTEGRATOR_SATURATE_EN for clamping instead of wrap-around.
module readout_integrator
   import readout_pkg::*;
#(
   parameter int unsigned INPUT_WIDTH = DEF_INPUT_WIDTH,
   parameter int unsigned ACC_WIDTH   = DEF_ACC_WIDTH,
   parameter int unsigned LEN_WIDTH   = DEF_LEN_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic        [LEN_WIDTH-1:0]   length,
   input  logic                          in_valid,
   input  logic signed [INPUT_WIDTH-1:0] i_in,
   input  logic signed [INPUT_WIDTH-1:0] q_in,
   output logic                          busy,
   output logic                          out_valid,
   output logic signed [ACC_WIDTH-1:0]   i_acc_out,
   output logic signed [ACC_WIDTH-1:0]   q_acc_out,
   output logic                          ovf
);

   state_e               state_q, state_d;
   logic [LEN_WIDTH-1:0] len_q;
   logic [LEN_WIDTH-1:0] cnt_q;
   logic [LEN_WIDTH-1:0] cnt_inc;
   logic                 ovf_q;
   logic                 accept;
   logic                 take;
   logic                 i_ovf;
   logic                 q_ovf;

   assign accept  = (state_q == StIdle) && start && (length != '0);
   assign take    = (state_q == StAccum) && in_valid;
   assign cnt_inc = cnt_q + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StAccum;
         StAccum: if (take && (cnt_inc == len_q)) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy      = (state_q != StIdle);
      out_valid = (state_q == StDone);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (accept) begin
         len_q <= length;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (take) begin
         cnt_q <= cnt_inc;
         ovf_q <= ovf_q | i_ovf | q_ovf;
      end
   end

   assign ovf = ovf_q;

   readout_acc_lane #(
      .INPUT_WIDTH (INPUT_WIDTH),
      .ACC_WIDTH   (ACC_WIDTH)
   ) u_lane_i (
      .clk     (clk),
      .rst     (rst),
      .clr     (accept),
      .en      (take),
      .din     (i_in),
      .acc     (i_acc_out),
      .ovf_det (i_ovf)
   );

   readout_acc_lane #(
      .INPUT_WIDTH (INPUT_WIDTH),
      .ACC_WIDTH   (ACC_WIDTH)
   ) u_lane_q (
      .clk     (clk),
      .rst     (rst),
      .clr     (accept),
      .en      (take),
      .din     (q_in),
      .acc     (q_acc_out),
      .ovf_det (q_ovf)
   );

endmodule

// File: tb/tb_readout_integrator.sv
// Bench for readout_integrator: default build plus a 16-bit-accumulator instance
// checked against a window-level arithmetic model.
module tb_readout_integrator;

`ifdef READOUT_INTEGRATOR_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef longint lq_t[$];

   logic               clk;
   logic               rst;
   logic               start;
   logic        [11:0] length;
   logic               in_valid;
   logic signed [15:0] i_in;
   logic signed [15:0] q_in;
   logic               busy, out_valid, ovf;
   logic signed [31:0] i_acc_out, q_acc_out;
   logic               busy16, out_valid16, ovf16;
   logic signed [15:0] i16, q16;

   int checks   = 0;
   int failures = 0;

   bit     vq[$];
   longint iq[$];
   longint qq[$];

   readout_integrator dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .length    (length),
      .in_valid  (in_valid),
      .i_in      (i_in),
      .q_in      (q_in),
      .busy      (busy),
      .out_valid (out_valid),
      .i_acc_out (i_acc_out),
      .q_acc_out (q_acc_out),
      .ovf       (ovf)
   );

   readout_integrator #(
      .INPUT_WIDTH (16),
      .ACC_WIDTH   (16),
      .LEN_WIDTH   (12)
   ) dut16 (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .length    (length),
      .in_valid  (in_valid),
      .i_in      (i_in),
      .q_in      (q_in),
      .busy      (busy16),
      .out_valid (out_valid16),
      .i_acc_out (i16),
      .q_acc_out (q16),
      .ovf       (ovf16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Window sum of a w-bit accumulator: wrap or clamp whenever the true sum leaves range.
   function automatic void model(input lq_t xs, input int w, output longint res, output bit ov);
      longint mx, mn, s;
      mx = (longint'(1) <<< (w - 1)) - 1;
      mn = -mx - 1;
      s  = 0;
      ov = 1'b0;
      foreach (xs[k]) begin
         s = s + xs[k];
         if (s > mx || s < mn) begin
            ov = 1'b1;
            if (SAT) s = (s > mx) ? mx : mn;
            else     s = (s > mx) ? s - 2 * (mx + 1) : s + 2 * (mx + 1);
         end
      end
      res = s;
   endfunction

   function automatic lq_t pick(input lq_t d);
      lq_t r;
      foreach (d[k]) if (vq[k]) r.push_back(d[k]);
      return r;
   endfunction

   // Start a window, replay the queued samples, report how many edges after
   // acceptance out_valid first appeared (-1 if never within the bound).
   task automatic play(input int len, input bit hold, output int seen);
      start    = 1'b1;
      length   = 12'(len);
      in_valid = 1'b0;
      step();
      start = hold;
      seen  = -1;
      foreach (vq[k]) begin
         in_valid = vq[k];
         i_in     = 16'(iq[k]);
         q_in     = 16'(qq[k]);
         step();
         if (out_valid && seen < 0) seen = k + 1;
      end
      in_valid = 1'b0;
      for (int k = 0; k < 4 && seen < 0; k++) begin
         step();
         if (out_valid) seen = 100 + k;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; length = '0; in_valid = 1'b0; i_in = '0; q_in = '0;
      step();
      step();
      checks += 5;
      if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      if (i_acc_out !== 32'sd0) begin failures++; $display("FAIL reset_i got %0d want 0", i_acc_out); end
      if (q_acc_out !== 32'sd0) begin failures++; $display("FAIL reset_q got %0d want 0", q_acc_out); end
      if (ovf !== 1'b0)       begin failures++; $display("FAIL reset_ovf got %b want 0", ovf); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      int seen;
      vq = '{1, 1, 1, 1};
      iq = '{1, 2, 3, 4};
      qq = '{-1, -1, -1, -1};
      play(4, 1'b0, seen);
      checks += 5;
      if (seen !== 4) begin failures++; $display("FAIL basic_latency got %0d want 4", seen); end
      if (i_acc_out !== 32'sd10) begin failures++; $display("FAIL basic_i got %0d want 10", i_acc_out); end
      if (q_acc_out !== -32'sd4) begin failures++; $display("FAIL basic_q got %0d want -4", q_acc_out); end
      if (ovf !== 1'b0) begin failures++; $display("FAIL basic_ovf got %b want 0", ovf); end
      if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_done got %b want 1", busy); end
      step();
      checks += 3;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_pulse_width got %b want 0", out_valid); end
      if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_idle got %b want 0", busy); end
      if (i_acc_out !== 32'sd10) begin failures++; $display("FAIL basic_hold got %0d want 10", i_acc_out); end
   endtask

   task automatic test_gaps();
      int seen;
      vq = '{1, 0, 0, 1, 0, 1};
      iq = '{100, 100, 100, 100, 100, 100};
      qq = '{100, 100, 100, 100, 100, 100};
      play(3, 1'b0, seen);
      checks += 3;
      if (seen !== 6) begin failures++; $display("FAIL gaps_latency got %0d want 6", seen); end
      if (i_acc_out !== 32'sd300) begin failures++; $display("FAIL gaps_i got %0d want 300", i_acc_out); end
      if (q_acc_out !== 32'sd300) begin failures++; $display("FAIL gaps_q got %0d want 300", q_acc_out); end
      step();
   endtask

   task automatic test_ignored_start();
      int seen;
      start = 1'b1; length = 12'd0;
      step();
      checks += 1;
      if (busy !== 1'b0) begin failures++; $display("FAIL len0_busy got %b want 0", busy); end
      start = 1'b0;
      step();
      checks += 2;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL len0_pulse got %b want 0", out_valid); end
      if (i_acc_out !== 32'sd300) begin failures++; $display("FAIL len0_sum got %0d want 300", i_acc_out); end
      // start stays high through ACCUM; a restart would clear the partial sum
      vq = '{1, 1, 1};
      iq = '{5, 6, 7};
      qq = '{-5, -6, -7};
      play(3, 1'b1, seen);
      checks += 3;
      if (seen !== 3) begin failures++; $display("FAIL accum_start_latency got %0d want 3", seen); end
      if (i_acc_out !== 32'sd18) begin failures++; $display("FAIL accum_start_i got %0d want 18", i_acc_out); end
      if (q_acc_out !== -32'sd18) begin failures++; $display("FAIL accum_start_q got %0d want -18", q_acc_out); end
      length = 12'd5;
      step();
      checks += 2;
      if (busy !== 1'b0) begin failures++; $display("FAIL done_start_busy got %b want 0", busy); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL done_start_pulse got %b want 0", out_valid); end
      start = 1'b0;
      step();
      checks += 2;
      if (busy !== 1'b0) begin failures++; $display("FAIL done_start_idle got %b want 0", busy); end
      if (i_acc_out !== 32'sd18) begin failures++; $display("FAIL done_start_sum got %0d want 18", i_acc_out); end
   endtask

   task automatic test_overflow();
      int     seen;
      longint eq16;
      bit     eo;
      longint ei16;
      ei16 = SAT ? 32767 : -2;
      vq = '{1, 1};
      iq = '{32767, 32767};
      qq = '{-32768, -32768};
      model(pick(qq), 16, eq16, eo);
      play(2, 1'b0, seen);
      checks += 6;
      if (i16 !== 16'(ei16)) begin failures++; $display("FAIL ovf16_i got %0d want %0d", i16, ei16); end
      if (q16 !== 16'(eq16)) begin failures++; $display("FAIL ovf16_q got %0d want %0d", q16, eq16); end
      if (ovf16 !== 1'b1) begin failures++; $display("FAIL ovf16_flag got %b want 1", ovf16); end
      if (i_acc_out !== 32'sd65534) begin failures++; $display("FAIL ovf32_i got %0d want 65534", i_acc_out); end
      if (q_acc_out !== -32'sd65536) begin failures++; $display("FAIL ovf32_q got %0d want -65536", q_acc_out); end
      if (ovf !== 1'b0) begin failures++; $display("FAIL ovf32_flag got %b want 0", ovf); end
      step();
   endtask

   task automatic test_reset_mid();
      int     seen;
      longint ei, eq;
      bit     eo;
      start = 1'b1; length = 12'd8; in_valid = 1'b0;
      step();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         i_in = 16'($urandom_range(1, 1000));
         q_in = 16'($urandom_range(1, 1000));
         step();
      end
      in_valid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks += 4;
      if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got %b want 0", busy); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_pulse got %b want 0", out_valid); end
      if (i_acc_out !== 32'sd0) begin failures++; $display("FAIL midrst_i got %0d want 0", i_acc_out); end
      if (q_acc_out !== 32'sd0) begin failures++; $display("FAIL midrst_q got %0d want 0", q_acc_out); end
      #2 rst = 1'b0;
      step();
      vq = '{1, 1};
      iq = '{-123, 456};
      qq = '{789, -10};
      play(2, 1'b0, seen);
      model(pick(iq), 32, ei, eo);
      model(pick(qq), 32, eq, eo);
      checks += 4;
      if (seen !== 2) begin failures++; $display("FAIL postrst_latency got %0d want 2", seen); end
      if (i_acc_out !== 32'(ei)) begin failures++; $display("FAIL postrst_i got %0d want %0d", i_acc_out, ei); end
      if (q_acc_out !== 32'(eq)) begin failures++; $display("FAIL postrst_q got %0d want %0d", q_acc_out, eq); end
      if (ovf !== 1'b0) begin failures++; $display("FAIL postrst_ovf got %b want 0", ovf); end
      step();
   endtask

   task automatic test_random();
      int                 seen, len, cnt;
      longint             ei, eq, ei16, eq16;
      bit                 eoi, eoq, eoi16, eoq16;
      logic signed [15:0] r;
      for (int w = 0; w < 20; w++) begin
         len = $urandom_range(1, 12);
         vq.delete(); iq.delete(); qq.delete();
         cnt = 0;
         while (cnt < len) begin
            bit v;
            v = ($urandom_range(0, 99) < 60);
            if (v) cnt++;
            vq.push_back(v);
            r = 16'($urandom); iq.push_back(longint'(r));
            r = 16'($urandom); qq.push_back(longint'(r));
         end
         model(pick(iq), 32, ei, eoi);
         model(pick(qq), 32, eq, eoq);
         model(pick(iq), 16, ei16, eoi16);
         model(pick(qq), 16, eq16, eoq16);
         play(len, 1'b0, seen);
         checks += 1;
         if (seen !== vq.size()) begin
            failures++; $display("FAIL rand_latency win %0d got %0d want %0d", w, seen, vq.size());
         end
         checks += 1;
         if (i_acc_out !== 32'(ei) || q_acc_out !== 32'(eq) || ovf !== (eoi | eoq)) begin
            failures++;
            $display("FAIL rand32 win %0d got i=%0d q=%0d ovf=%b want i=%0d q=%0d ovf=%b",
                     w, i_acc_out, q_acc_out, ovf, ei, eq, eoi | eoq);
         end
         checks += 1;
         if (i16 !== 16'(ei16) || q16 !== 16'(eq16) || ovf16 !== (eoi16 | eoq16)) begin
            failures++;
            $display("FAIL rand16 win %0d got i=%0d q=%0d ovf=%b want i=%0d q=%0d ovf=%b",
                     w, i16, q16, ovf16, ei16, eq16, eoi16 | eoq16);
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      int                 last, pulses;
      logic signed [15:0] cur_i, cur_q;
      last = -1; pulses = 0;
      start = 1'b1; length = 12'd1; in_valid = 1'b1;
      for (int c = 0; c < 40; c++) begin
         cur_i = 16'($urandom);
         cur_q = 16'($urandom);
         i_in  = cur_i;
         q_in  = cur_q;
         step();
         if (out_valid) begin
            pulses++;
            checks += 1;
            if (i_acc_out !== 32'(cur_i) || q_acc_out !== 32'(cur_q)) begin
               failures++;
               $display("FAIL b2b_sum cyc %0d got i=%0d q=%0d want i=%0d q=%0d",
                        c, i_acc_out, q_acc_out, cur_i, cur_q);
            end
            if (last >= 0) begin
               checks += 1;
               if (c - last !== 3) begin
                  failures++; $display("FAIL b2b_period got %0d want 3", c - last);
               end
            end
            last = c;
         end
      end
      start = 1'b0; in_valid = 1'b0;
      checks += 1;
      if (pulses < 12) begin failures++; $display("FAIL b2b_count got %0d want >=12", pulses); end
      step();
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_ignored_start();
      test_overflow();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
